// File: rtl/svi_array_rr_collector_if.sv
// svi_ch: one valid/ready producer channel feeding the collector.
// The producer drives valid/data; the collector drives ready.
interface svi_ch #(
    parameter int WIDTH = 8
);
    logic             valid;
    logic [WIDTH-1:0] data;
    logic             ready;

    modport src (
        output valid,
        output data,
        input  ready
    );

    modport snk (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/svi_array_rr_collector.sv
// svi_array_rr_collector: merges N_CH svi_ch channels into one registered
// valid/ready stream with round-robin fairness. Option macro: SVI_RRC_STATS_EN.
module svi_array_rr_collector #(
    parameter int N_CH  = 8,
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    svi_ch.snk                       u_I [N_CH-1:0],
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(N_CH)-1:0]  o_ch
`ifdef SVI_RRC_STATS_EN
    ,
    output logic [N_CH*CNT_W-1:0]    o_cnt
`endif
);

    localparam int CH_W = $clog2(N_CH);

    logic [N_CH-1:0]  in_valid;
    logic [WIDTH-1:0] in_data [N_CH];
    logic [N_CH-1:0]  ch_ready;
    logic [N_CH-1:0]  accept;

    logic [N_CH-1:0]  full;
    logic [WIDTH-1:0] hold [N_CH];
    logic [CH_W-1:0]  rr;

    logic             load;
    logic             gnt_any;
    logic [CH_W-1:0]  gnt_idx;
    logic [CH_W-1:0]  cand;
    logic [N_CH-1:0]  grant;

    // Flatten the interface array into plain vectors.
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign in_valid[c]  = u_I[c].valid;
        assign in_data[c]   = u_I[c].data;
        assign u_I[c].ready = ch_ready[c];
    end

    assign load     = !o_valid || i_ready;
    assign ch_ready = {N_CH{i_rst_n}} & (~full | grant);
    assign accept   = in_valid & ch_ready;

    // Round-robin pick: first full channel after rr, wrapping at N_CH-1.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        grant   = '0;
        if (load) begin
            for (int k = 1; k <= N_CH; k++) begin
                cand = CH_W'((int'(rr) + k) % N_CH);
                if (!gnt_any && full[cand]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
        if (gnt_any) begin
            grant[gnt_idx] = 1'b1;
        end
    end

    // Occupancy flags: set on accept, cleared when granted and not refilled.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            full <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (accept[c]) begin
                    full[c] <= 1'b1;
                end else if (grant[c]) begin
                    full[c] <= 1'b0;
                end
            end
        end
    end

    // Hold data captures on accept; contents are ignored while empty.
    always_ff @(posedge i_clk) begin
        for (int c = 0; c < N_CH; c++) begin
            if (accept[c]) begin
                hold[c] <= in_data[c];
            end
        end
    end

    // Output register and rr pointer; frozen while stalled downstream.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_ch    <= '0;
            rr      <= CH_W'(N_CH - 1);
        end else if (load) begin
            if (gnt_any) begin
                o_valid <= 1'b1;
                o_data  <= hold[gnt_idx];
                o_ch    <= gnt_idx;
                rr      <= gnt_idx;
            end else begin
                o_valid <= 1'b0;
            end
        end
    end

`ifdef SVI_RRC_STATS_EN
    logic [CNT_W-1:0] cnt [N_CH];

    // Per-channel accept counters, saturating at all-ones.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int c = 0; c < N_CH; c++) begin
                cnt[c] <= '0;
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (accept[c] && (cnt[c] != {CNT_W{1'b1}})) begin
                    cnt[c] <= cnt[c] + 1'b1;
                end
            end
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_cnt
        assign o_cnt[c*CNT_W +: CNT_W] = cnt[c];
    end
`else
    // CNT_W only sizes the stats counters, absent in this build.
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
`endif

endmodule

// File: tb/tb_svi_array_rr_collector.sv
// tb_svi_array_rr_collector: directed + random checks of the round-robin
// collector against a per-channel order scoreboard.
module tb_svi_array_rr_collector;

    localparam int N_CH  = 8;
    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
    localparam int CH_W  = 3;

    typedef struct packed {
        logic [CH_W-1:0]  ch;
        logic [WIDTH-1:0] data;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_data;
    logic [CH_W-1:0]  o_ch;
`ifdef SVI_RRC_STATS_EN
    logic [N_CH*CNT_W-1:0] o_cnt;
`endif

    logic [N_CH-1:0]  tb_valid;
    logic [WIDTH-1:0] tb_data [N_CH];
    logic [N_CH-1:0]  tb_rdy;

    int n_cmp;
    int n_err;

    exp_t exp_q [$];

    svi_ch #(.WIDTH(WIDTH)) u_if [N_CH-1:0] ();

    for (genvar g = 0; g < N_CH; g++) begin : g_drv
        assign u_if[g].valid = tb_valid[g];
        assign u_if[g].data  = tb_data[g];
        assign tb_rdy[g]     = u_if[g].ready;
    end

    svi_array_rr_collector #(
        .N_CH (N_CH),
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .u_I    (u_if),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_data (o_data),
        .o_ch   (o_ch)
`ifdef SVI_RRC_STATS_EN
        ,
        .o_cnt  (o_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (o_valid) ok = 1'b1;
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: o_valid never rose within 20 cycles", name);
        end
    endtask

    task automatic drain(input string name);
        step();
        tb_valid = '0;
        i_ready  = 1'b1;
        repeat (N_CH + 6) @(posedge clk);
        @(negedge clk);
        chk({name, "_ovalid"}, 64'(o_valid), 64'd0);
        chk({name, "_left"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard monitor: record accepts, check every transferred beat
    // against the oldest outstanding word of its channel, and check that
    // a stalled output stays frozen.
    logic             pv, pr, have_prev;
    logic [WIDTH-1:0] pd;
    logic [CH_W-1:0]  pc;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            have_prev = 1'b0;
        end else begin
            if (have_prev && pv && !pr) begin
                n_cmp++;
                if (!(o_valid === 1'b1 && o_data === pd && o_ch === pc)) begin
                    n_err++;
                    $display("FAIL stall_hold: got v=%0b d=%0h ch=%0d, expected v=1 d=%0h ch=%0d",
                             o_valid, o_data, o_ch, pd, pc);
                end
            end
            if (o_valid && i_ready) begin
                int found;
                found = -1;
                foreach (exp_q[i]) begin
                    if (found < 0 && exp_q[i].ch == o_ch) found = i;
                end
                n_cmp++;
                if (found < 0) begin
                    n_err++;
                    $display("FAIL beat_exists: got ch=%0d d=%0h, expected no beat (none pending)",
                             o_ch, o_data);
                end else begin
                    if (exp_q[found].data !== o_data) begin
                        n_err++;
                        $display("FAIL beat_data ch%0d: got %0h, expected %0h",
                                 o_ch, o_data, exp_q[found].data);
                    end
                    exp_q.delete(found);
                end
            end
            for (int c = 0; c < N_CH; c++) begin
                if (tb_valid[c] && tb_rdy[c]) begin
                    exp_q.push_back('{ch: CH_W'(c), data: tb_data[c]});
                end
            end
            pv = o_valid;
            pr = i_ready;
            pd = o_data;
            pc = o_ch;
            have_prev = 1'b1;
        end
    end

    logic [WIDTH-1:0] snap_d;
    logic [CH_W-1:0]  snap_c;
    logic             a0, a1;

    initial begin
        n_cmp = 0;
        n_err = 0;
        have_prev = 1'b0;
        rst_n    = 1'b0;
        i_ready  = 1'b1;
        tb_valid = '1;
        for (int c = 0; c < N_CH; c++) tb_data[c] = WIDTH'(c);

        // Reset held two cycles with every producer valid.
        repeat (2) begin
            @(negedge clk);
            chk("rst_ovalid", 64'(o_valid), 64'd0);
            chk("rst_odata", 64'(o_data), 64'd0);
            chk("rst_och", 64'(o_ch), 64'd0);
            chk("rst_ready", 64'(tb_rdy), 64'd0);
        end
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready", 64'(tb_rdy), 64'hFF);

        // All channels saturated: strict 0..7 rotation, data == channel.
        wait_valid("rr_start");
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("rr_ch%0d", i), 64'(o_ch), 64'(i % N_CH));
            chk($sformatf("rr_data%0d", i), 64'(o_data), 64'(i % N_CH));
        end
        drain("rr_drain");

        // Single word on ch3: visible exactly two cycles later, one beat.
        step();
        tb_valid[3] = 1'b1;
        tb_data[3]  = 8'hA5;
        @(negedge clk);
        chk("single_rdy", 64'(tb_rdy[3]), 64'd1);
        step();
        tb_valid[3] = 1'b0;
        @(negedge clk);
        chk("single_k1_valid", 64'(o_valid), 64'd0);
        @(negedge clk);
        chk("single_k2_valid", 64'(o_valid), 64'd1);
        chk("single_k2_data", 64'(o_data), 64'hA5);
        chk("single_k2_ch", 64'(o_ch), 64'd3);
        @(negedge clk);
        chk("single_k3_valid", 64'(o_valid), 64'd0);

        // Backpressure: ch0/ch1 stream, downstream stalls for 5 cycles.
        step();
        tb_valid[0] = 1'b1;
        tb_valid[1] = 1'b1;
        tb_data[0]  = 8'h10;
        tb_data[1]  = 8'h80;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            a0 = tb_rdy[0];
            a1 = tb_rdy[1];
            if (i == 3) begin
                snap_d = o_data;
                snap_c = o_ch;
                chk("bp_valid", 64'(o_valid), 64'd1);
            end else if (i > 3 && i < 8) begin
                chk($sformatf("bp_data%0d", i), 64'(o_data), 64'(snap_d));
                chk($sformatf("bp_ch%0d", i), 64'(o_ch), 64'(snap_c));
            end
            if (i == 7) chk("bp_ready_drop", 64'(tb_rdy[1:0]), 64'd0);
            step();
            if (a0) tb_data[0] = tb_data[0] + 1'b1;
            if (a1) tb_data[1] = tb_data[1] + 1'b1;
            i_ready = !((i + 1) >= 3 && (i + 1) < 8);
        end
        drain("bp_drain");

        // Random traffic and random downstream stalls.
        for (int i = 0; i < 600; i++) begin
            step();
            for (int c = 0; c < N_CH; c++) begin
                tb_valid[c] = ($urandom_range(0, 99) < 40);
                tb_data[c]  = WIDTH'($urandom);
            end
            i_ready = ($urandom_range(0, 99) < 60);
        end
        drain("rand_drain");

        // Reset mid-stream with output valid and holds full.
        step();
        tb_valid = '1;
        i_ready  = 1'b0;
        for (int c = 0; c < N_CH; c++) tb_data[c] = WIDTH'($urandom);
        repeat (4) step();
        @(negedge clk);
        chk("mid_pre_valid", 64'(o_valid), 64'd1);
        step();
        rst_n    = 1'b0;
        tb_valid = '0;
        i_ready  = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", 64'(tb_rdy), 64'd0);
        @(negedge clk);
        chk("mid_rst_ovalid", 64'(o_valid), 64'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_empty", 64'(tb_rdy), 64'hFF);
        step();
        tb_valid[7] = 1'b1;
        tb_data[7]  = 8'hC3;
        tb_valid[0] = 1'b1;
        tb_data[0]  = 8'h3C;
        step();
        tb_valid = '0;
        wait_valid("mid_restart");
        chk("mid_first_ch", 64'(o_ch), 64'd0);
        chk("mid_first_data", 64'(o_data), 64'h3C);
        @(negedge clk);
        chk("mid_second_ch", 64'(o_ch), 64'd7);
        chk("mid_second_data", 64'(o_data), 64'hC3);
        drain("mid_drain");

`ifdef SVI_RRC_STATS_EN
        // Accept counters: 20 words on ch2 saturate a 4-bit field.
        begin
            int acc;
            logic [N_CH*CNT_W-1:0] e;
            step();
            rst_n = 1'b0;
            @(negedge clk);
            step();
            rst_n = 1'b1;
            @(negedge clk);
            chk("stats_reset", 64'(o_cnt), 64'd0);
            step();
            tb_valid[2] = 1'b1;
            tb_data[2]  = 8'h5A;
            acc = 0;
            for (int i = 0; i < 100 && acc < 20; i++) begin
                @(negedge clk);
                if (tb_rdy[2]) acc++;
                step();
                if (acc >= 20) tb_valid[2] = 1'b0;
            end
            tb_valid[2] = 1'b0;
            chk("stats_accepts", 64'(acc), 64'd20);
            e = '0;
            e[2*CNT_W +: CNT_W] = (acc > 15) ? CNT_W'(15) : CNT_W'(acc);
            @(negedge clk);
            chk("stats_cnt", 64'(o_cnt), 64'(e));
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
